// File: rtl/smul_sched.sv
// Job scheduler for a cascaded multiplier chain: sequences clear, operand issue,
// pipeline drain and completion, and tracks result validity through the chain latency.
module smul_sched #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_prec,
  input  logic [CNT_W-1:0] job_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mul_ce,
  output logic             mul_sclr,
  output logic [3:0]       mul_select_precision,
  output logic             mul_active_chain,
  output logic             res_valid,
  output logic             res_last,
  output logic             done,
  output logic             err_prec,
  output logic             busy
);

  localparam logic [1:0] PREC_INT8  = 2'b00;
  localparam logic [1:0] PREC_INT16 = 2'b01;
  localparam logic [1:0] PREC_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       len_q;
  logic [CNT_W-1:0]       issue_cnt;
  logic [CNT_W-1:0]       res_cnt;
  logic [MUL_LATENCY-1:0] vld_sr;
  logic [MUL_LATENCY-1:0] sr_nxt;
  logic [3:0]             sel_nxt;
  logic                   chain_nxt;
  logic                   err_nxt;
  logic                   job_acc;
  logic                   beat_acc;
  logic                   beat_last;
  logic                   res_last_nxt;

  assign job_acc   = job_valid & job_ready;
  assign beat_acc  = in_valid & in_ready;
  assign beat_last = beat_acc && (issue_cnt == len_q - CNT_W'(1));
  assign res_valid = vld_sr[MUL_LATENCY-1];

  // Valid shift register: the top bit is the result valid for the current cycle.
  always_comb begin
    sr_nxt    = vld_sr;
    sr_nxt[0] = beat_acc;
    for (int i = 1; i < int'(MUL_LATENCY); i++) begin
      sr_nxt[i] = vld_sr[i-1];
    end
  end

  // The result entering the output stage is last when all earlier results have already left.
  assign res_last_nxt = mul_ce & sr_nxt[MUL_LATENCY-1] &
                        ((res_cnt + CNT_W'(res_valid)) == (len_q - CNT_W'(1)));

  always_comb begin
    state_nxt = state;
    sel_nxt   = mul_select_precision;
    chain_nxt = mul_active_chain;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_acc) begin
          if (job_prec == PREC_RSVD) begin
            err_nxt = 1'b1;
          end else if (job_len == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_CLEAR;
            case (job_prec)
              PREC_INT8:  begin sel_nxt = 4'b0011; chain_nxt = 1'b0; end
              PREC_INT16: begin sel_nxt = 4'b0100; chain_nxt = 1'b0; end
              default:    begin sel_nxt = 4'b1000; chain_nxt = 1'b1; end
            endcase
          end
        end
      end
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if (beat_last) state_nxt = S_DRAIN;
      S_DRAIN: if (res_last) state_nxt = S_DONE;
      S_DONE: begin
        state_nxt = S_IDLE;
        sel_nxt   = 4'b0000;
        chain_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        sel_nxt   = 4'b0000;
        chain_nxt = 1'b0;
      end
    endcase
  end

  // State, registered control outputs, counters and the valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      job_ready            <= 1'b1;
      in_ready             <= 1'b0;
      mul_ce               <= 1'b0;
      mul_sclr             <= 1'b0;
      mul_select_precision <= 4'b0000;
      mul_active_chain     <= 1'b0;
      res_last             <= 1'b0;
      done                 <= 1'b0;
      err_prec             <= 1'b0;
      busy                 <= 1'b0;
      len_q                <= '0;
      issue_cnt            <= '0;
      res_cnt              <= '0;
      vld_sr               <= '0;
    end else begin
      state                <= state_nxt;
      job_ready            <= (state_nxt == S_IDLE);
      in_ready             <= (state_nxt == S_RUN);
      mul_ce               <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      mul_sclr             <= (state_nxt == S_CLEAR);
      mul_select_precision <= sel_nxt;
      mul_active_chain     <= chain_nxt;
      done                 <= (state_nxt == S_DONE);
      err_prec             <= err_nxt;
      busy                 <= (state_nxt != S_IDLE);
      res_last             <= res_last_nxt;
      if (job_acc && (job_prec != PREC_RSVD) && (job_len != '0)) begin
        len_q <= job_len;
      end
      if (state == S_CLEAR) begin
        issue_cnt <= '0;
        res_cnt   <= '0;
      end else begin
        if (beat_acc)  issue_cnt <= issue_cnt + CNT_W'(1);
        if (res_valid) res_cnt   <= res_cnt + CNT_W'(1);
      end
      if (mul_ce) begin
        vld_sr <= sr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_smul_sched.sv
// Scoreboard bench for smul_sched: a cycle-timing reference model predicts control
// outputs and result timing; a negedge monitor compares against the DUT.
module tb_smul_sched;

  localparam int unsigned LAT = 3;
  localparam int unsigned CW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [1:0]    job_prec;
  logic [CW-1:0] job_len;
  logic          in_valid;
  logic          in_ready;
  logic          mul_ce;
  logic          mul_sclr;
  logic [3:0]    mul_select_precision;
  logic          mul_active_chain;
  logic          res_valid;
  logic          res_last;
  logic          done;
  logic          err_prec;
  logic          busy;

  smul_sched #(.MUL_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .job_valid            (job_valid),
    .job_ready            (job_ready),
    .job_prec             (job_prec),
    .job_len              (job_len),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .mul_ce               (mul_ce),
    .mul_sclr             (mul_sclr),
    .mul_select_precision (mul_select_precision),
    .mul_active_chain     (mul_active_chain),
    .res_valid            (res_valid),
    .res_last             (res_last),
    .done                 (done),
    .err_prec             (err_prec),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] lane_map(input logic [1:0] p);
    case (p)
      2'b00:   return 5'b0011_0;
      2'b01:   return 5'b0100_0;
      default: return 5'b1000_1;
    endcase
  endfunction

  // Reference model: a job is a busy window; each accepted beat returns exactly LAT cycles later.
  typedef struct { int cyc; bit last; } res_t;
  res_t res_q[$];
  int   err_q[$];
  bit   m_active, m_zero;
  int   m_acc, m_len, m_issued, m_done_cyc;
  logic [4:0]  m_lane;
  logic        e_run, e_in_ready, e_jr, e_ce, e_done, e_sclr, e_rv, e_err;
  logic [10:0] e_ctrl;
  res_t        r;

  localparam logic [13:0] RST_VEC = 14'b1_0_0_0_0000_0_0_0_0_0_0;
  wire [13:0] out_vec = {job_ready, in_ready, mul_ce, mul_sclr, mul_select_precision,
                         mul_active_chain, res_valid, res_last, done, err_prec, busy};

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", 32'(out_vec), 32'(RST_VEC));
      res_q.delete();
      err_q.delete();
      m_active = 1'b0;
    end else begin
      e_run      = m_active && !m_zero && (cyc >= m_acc + 2);
      e_in_ready = e_run && (m_issued < m_len);
      e_ce       = e_run && ((m_done_cyc < 0) || (cyc < m_done_cyc));
      e_sclr     = m_active && !m_zero && (cyc == m_acc + 1);
      e_done     = m_active && (cyc == m_done_cyc);
      e_jr       = !m_active;
      e_ctrl     = {e_jr, m_active, e_in_ready, e_ce, e_sclr, e_done,
                    (m_active && !m_zero) ? m_lane : 5'b0};
      chk("ctrl", 32'({job_ready, busy, in_ready, mul_ce, mul_sclr, done,
                       mul_select_precision, mul_active_chain}), 32'(e_ctrl));

      e_err = (err_q.size() > 0) && (err_q[0] == cyc);
      if (e_err) void'(err_q.pop_front());
      chk("err_prec", 32'(err_prec), 32'(e_err));

      e_rv = (res_q.size() > 0) && (res_q[0].cyc == cyc);
      if (e_rv) begin
        r = res_q.pop_front();
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_last", 32'(res_last), 32'(r.last));
      end else begin
        chk("res_idle", 32'({res_valid, res_last}), 32'd0);
      end

      if (e_done) m_active = 1'b0;

      if (in_valid && e_in_ready) begin
        m_issued++;
        res_q.push_back('{cyc: cyc + LAT, last: (m_issued == m_len)});
        if (m_issued == m_len) m_done_cyc = cyc + LAT + 1;
      end
      if (job_valid && e_jr) begin
        if (job_prec == 2'b11) begin
          err_q.push_back(cyc + 1);
        end else begin
          m_active   = 1'b1;
          m_acc      = cyc;
          m_zero     = (job_len == '0);
          m_len      = int'(job_len);
          m_issued   = 0;
          m_done_cyc = m_zero ? cyc + 1 : -1;
          m_lane     = lane_map(job_prec);
        end
      end
    end
  end

  logic [3:0] pat = 4'b1101;

  task automatic send_job(input logic [1:0] p, input logic [CW-1:0] l, input bit hold);
    int n = 0;
    job_prec  = p;
    job_len   = l;
    job_valid = 1'b1;
    while (!job_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!job_ready) chk("job_ready_wait", 32'(job_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold) job_valid = 1'b0;
  endtask

  task automatic drive_beats(input int n_beats, input int mode);
    int got = 0;
    int k   = 0;
    int t   = 0;
    logic v;
    while (got < n_beats && t < 2000) begin
      if (in_ready) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = ($urandom_range(0, 3) != 0);
          default: begin v = pat[k % 4]; k++; end
        endcase
        in_valid = v;
        if (v) got++;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (got < n_beats) chk("beat_wait", 32'(got), 32'(n_beats));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(job_ready && !busy) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(job_ready && !busy)) chk("idle_wait", 32'(job_ready), 32'd1);
  endtask

  task automatic run_job(input logic [1:0] p, input logic [CW-1:0] l, input int mode);
    send_job(p, l, 1'b0);
    if (p != 2'b11 && l != '0) drive_beats(int'(l), mode);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d checks=%0d", cyc, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]    rp;
    logic [CW-1:0] rl;
    int            sel;
    rst       = 1'b1;
    job_valid = 1'b0;
    job_prec  = 2'b00;
    job_len   = '0;
    in_valid  = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(2'b00, CW'(4), 0);          // INT8, in_valid held high
    run_job(2'b10, CW'(3), 2);          // INT32, in_valid 1,0,1,1
    run_job(2'b11, CW'(5), 0);          // reserved precision
    run_job(2'b00, CW'(0), 0);          // zero-length job
    run_job(2'b01, CW'((1 << CW) - 1), 1); // maximum length, no wrap

    // Reset with two results still in the pipeline.
    send_job(2'b10, CW'(8), 1'b0);
    drive_beats(2, 0);
    rst = 1'b1;
    #1;
    chk("reset_async", 32'(out_vec), 32'(RST_VEC));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run_job(2'b01, CW'(5), 1);

    // Back-to-back with job_valid held high.
    send_job(2'b00, CW'(3), 1'b1);
    drive_beats(3, 0);
    send_job(2'b10, CW'(2), 1'b0);
    drive_beats(2, 0);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      rp  = (sel == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sel = $urandom_range(0, 11);
      rl  = (sel == 0) ? '0 : (sel == 1) ? CW'((1 << CW) - 1) : CW'($urandom_range(1, 10));
      run_job(rp, rl, int'($urandom_range(0, 1)));
    end

    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
